// File: rtl/mem_arbiter_pkg.sv
// Shared definitions for the two-port memory arbiter: state encoding and default widths.
package mem_arbiter_pkg;

    localparam int ADDR_W_DEF = 12;
    localparam int DATA_W_DEF = 16;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } arbState_t;

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way round-robin grant. The pointer names the port that wins the next tie
// and only moves when the caller commits a grant.
module rr_arbiter2 (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req,
    input  logic       update,
    output logic       anyReq,
    output logic       winner
);

    logic favour;

    always_comb begin
        anyReq = |req;
        winner = 1'b0;
        if (req == 2'b11) begin
            winner = favour;
        end else begin
            winner = req[1];
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            favour <= 1'b0;
        end else if (update && anyReq) begin
            favour <= ~winner;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Two-requester single-port memory arbiter: IDLE -> ACCESS -> DONE, one access per three cycles.
//   state  | meaning
//   IDLE   | waiting for a request; latch winner and its command
//   ACCESS | drive memory strobes from latched command
//   DONE   | pulse ack to the granted port, return to IDLE
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req0,
    input  logic              we0,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [DATA_W-1:0] wdata0,
    input  logic              req1,
    input  logic              we1,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [DATA_W-1:0] wdata1,
    output logic              ack0,
    output logic              ack1,
    output logic [DATA_W-1:0] rdata,
    output logic              busy,
    output logic [ADDR_W-1:0] memAdr,
    output logic [DATA_W-1:0] writeData,
    output logic              memRead,
    output logic              memWrite,
    input  logic [DATA_W-1:0] readData
);

    arbState_t         state;
    arbState_t         nextState;
    logic              anyReq;
    logic              winner;
    logic              grantUpdate;
    logic              idxLat;
    logic              weLat;
    logic [ADDR_W-1:0] addrLat;
    logic [DATA_W-1:0] wdataLat;

    rr_arbiter2 uRr (
        .clk    (clk),
        .rst    (rst),
        .req    ({req1, req0}),
        .update (grantUpdate),
        .anyReq (anyReq),
        .winner (winner)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= nextState;
        end
    end

    // Strobes decode straight from state, so an async reset kills a pending write at once.
    always_comb begin
        nextState   = state;
        grantUpdate = 1'b0;
        memAdr      = '0;
        writeData   = '0;
        memRead     = 1'b0;
        memWrite    = 1'b0;
        ack0        = 1'b0;
        ack1        = 1'b0;
        case (state)
            IDLE: begin
                if (anyReq) begin
                    nextState   = ACCESS;
                    grantUpdate = 1'b1;
                end
            end
            ACCESS: begin
                memAdr    = addrLat;
                writeData = wdataLat;
                memWrite  = weLat;
                memRead   = ~weLat;
                nextState = DONE;
            end
            DONE: begin
                ack0      = ~idxLat;
                ack1      = idxLat;
                nextState = IDLE;
            end
            default: nextState = IDLE;
        endcase
    end

    assign busy = (state != IDLE);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            idxLat   <= 1'b0;
            weLat    <= 1'b0;
            addrLat  <= '0;
            wdataLat <= '0;
            rdata    <= '0;
        end else begin
            if (state == IDLE && anyReq) begin
                idxLat   <= winner;
                weLat    <= winner ? we1 : we0;
                addrLat  <= winner ? addr1 : addr0;
                wdataLat <= winner ? wdata1 : wdata0;
            end
            if (state == ACCESS && !weLat) begin
                rdata <= readData;
            end
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with a memory model and an ack scoreboard.
module tb_mem_arbiter;
    import mem_arbiter_pkg::*;

    localparam int AW = 12;
    localparam int DW = 16;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          req0 = 1'b0, we0 = 1'b0, req1 = 1'b0, we1 = 1'b0;
    logic [AW-1:0] addr0 = '0, addr1 = '0;
    logic [DW-1:0] wdata0 = '0, wdata1 = '0;
    logic          ack0, ack1, busy, memRead, memWrite;
    logic [DW-1:0] rdata, writeData, readData;
    logic [AW-1:0] memAdr;

    logic          preloadEn = 1'b0;
    logic [AW-1:0] preAddr = '0;
    logic [DW-1:0] preData = '0;
    logic [DW-1:0] memModel [0:4095];

    typedef struct {
        bit            port;
        bit            isRead;
        logic [DW-1:0] data;
    } exp_t;

    exp_t sbQ[$];
    bit   grantLog[$];
    int   grantCyc[$];
    int   tests = 0;
    int   fails = 0;
    int   cyc = 0;
    int   start = 0;
    bit   autoDrop = 1'b1;

    mem_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
        .clk       (clk),
        .rst       (rst),
        .req0      (req0),
        .we0       (we0),
        .addr0     (addr0),
        .wdata0    (wdata0),
        .req1      (req1),
        .we1       (we1),
        .addr1     (addr1),
        .wdata1    (wdata1),
        .ack0      (ack0),
        .ack1      (ack1),
        .rdata     (rdata),
        .busy      (busy),
        .memAdr    (memAdr),
        .writeData (writeData),
        .memRead   (memRead),
        .memWrite  (memWrite),
        .readData  (readData)
    );

    always #5 clk = ~clk;

    assign readData = memModel[memAdr];

    always @(posedge clk) begin
        if (preloadEn) memModel[preAddr] <= preData;
        else if (memWrite) memModel[memAdr] <= writeData;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // One cycle: sample at the falling edge, retire any ack against the scoreboard.
    task automatic step();
        exp_t e;
        @(negedge clk);
        cyc++;
        check("ackExclusive", 32'(ack0 & ack1), 32'd0);
        check("rwExclusive", 32'(memRead & memWrite), 32'd0);
        if (ack0 || ack1) begin
            if (sbQ.size() == 0) begin
                check("unexpectedAck", 32'({ack1, ack0}), 32'd0);
            end else begin
                e = sbQ.pop_front();
                check("ackPort", 32'(ack1), 32'(e.port));
                if (e.isRead) check("rdata", 32'(rdata), 32'(e.data));
            end
            grantLog.push_back(ack1);
            grantCyc.push_back(cyc);
            if (autoDrop) begin
                if (ack0) req0 = 1'b0;
                if (ack1) req1 = 1'b0;
            end
        end
    endtask

    task automatic drain(input int bound);
        for (int i = 0; i < bound && sbQ.size() != 0; i++) step();
        check("drainTimeout", 32'(sbQ.size()), 32'd0);
    endtask

    initial begin
        #1 rst = 1'b0;
        preloadEn = 1'b1; preAddr = 12'h010; preData = 16'hBEEF;
        step();
        preAddr = 12'h020; preData = 16'h0000;
        step();
        preloadEn = 1'b0;

        check("rstBusy", 32'(busy), 32'd0);
        check("rstAck", 32'({ack1, ack0}), 32'd0);
        check("rstRdata", 32'(rdata), 32'd0);
        check("rstStrobes", 32'({memRead, memWrite}), 32'd0);
        check("rstMemAdr", 32'(memAdr), 32'd0);
        check("rstWriteData", 32'(writeData), 32'd0);
        rst = 1'b1;

        // single read
        req0 = 1'b1; we0 = 1'b0; addr0 = 12'h010;
        sbQ.push_back('{1'b0, 1'b1, 16'hBEEF});
        start = cyc;
        step();
        check("rdMemRead", 32'(memRead), 32'd1);
        check("rdMemWrite", 32'(memWrite), 32'd0);
        check("rdMemAdr", 32'(memAdr), 32'h010);
        check("rdBusy", 32'(busy), 32'd1);
        check("rdNoEarlyAck", 32'(ack0), 32'd0);
        step();
        check("rdAck0", 32'(ack0), 32'd1);
        check("rdLatency", 32'(grantCyc[$] - start), 32'd2);
        step();
        check("rdIdleBusy", 32'(busy), 32'd0);
        check("rdIdleStrobe", 32'({memRead, memAdr}), 32'd0);

        // single write
        req1 = 1'b1; we1 = 1'b1; addr1 = 12'hFFF; wdata1 = 16'h1234;
        sbQ.push_back('{1'b1, 1'b0, 16'h0000});
        start = cyc;
        step();
        check("wrMemWrite", 32'(memWrite), 32'd1);
        check("wrMemRead", 32'(memRead), 32'd0);
        check("wrMemAdr", 32'(memAdr), 32'hFFF);
        check("wrData", 32'(writeData), 32'h1234);
        step();
        check("wrAck", 32'({ack1, ack0}), 32'b10);
        check("wrRdataHold", 32'(rdata), 32'hBEEF);
        check("wrLatency", 32'(grantCyc[$] - start), 32'd2);
        we1 = 1'b0;
        step();

        req0 = 1'b1; addr0 = 12'hFFF;
        sbQ.push_back('{1'b0, 1'b1, 16'h1234});
        drain(10);

        // tie straight after reset: port 0 first
        rst = 1'b0;
        step();
        check("rst2Rdata", 32'(rdata), 32'd0);
        rst = 1'b1;
        grantLog.delete(); grantCyc.delete();
        req0 = 1'b1; addr0 = 12'h010; req1 = 1'b1; addr1 = 12'hFFF;
        sbQ.push_back('{1'b0, 1'b1, 16'hBEEF});
        sbQ.push_back('{1'b1, 1'b1, 16'h1234});
        start = cyc;
        drain(12);
        check("tie1First", 32'(grantLog[0]), 32'd0);
        check("tie1Second", 32'(grantLog[1]), 32'd1);
        check("tie1Lat0", 32'(grantCyc[0] - start), 32'd2);
        check("tie1Lat1", 32'(grantCyc[1] - start), 32'd5);

        step();
        grantLog.delete(); grantCyc.delete();
        req0 = 1'b1; req1 = 1'b1;
        sbQ.push_back('{1'b0, 1'b1, 16'hBEEF});
        sbQ.push_back('{1'b1, 1'b1, 16'h1234});
        drain(12);
        check("tie2First", 32'(grantLog[0]), 32'd0);
        check("tie2Second", 32'(grantLog[1]), 32'd1);

        // sustained contention
        step();
        grantLog.delete(); grantCyc.delete();
        autoDrop = 1'b0;
        req0 = 1'b1; req1 = 1'b1;
        for (int i = 0; i < 4; i++) begin
            if (i % 2 == 0) sbQ.push_back('{1'b0, 1'b1, 16'hBEEF});
            else            sbQ.push_back('{1'b1, 1'b1, 16'h1234});
        end
        for (int i = 0; i < 12; i++) step();
        req0 = 1'b0; req1 = 1'b0;
        autoDrop = 1'b1;
        check("fairCount", 32'(grantLog.size()), 32'd4);
        check("fairFirst", 32'(grantLog[0]), 32'd0);
        for (int i = 1; i < 4; i++) check("fairAlternate", 32'(grantLog[i] ^ grantLog[i-1]), 32'd1);
        check("fairSbEmpty", 32'(sbQ.size()), 32'd0);

        // reset in the middle of a write
        step();
        req1 = 1'b1; we1 = 1'b1; addr1 = 12'h020; wdata1 = 16'h5555;
        step();
        check("abortPreWrite", 32'(memWrite), 32'd1);
        #2 rst = 1'b0;
        #1;
        check("abortMemWrite", 32'(memWrite), 32'd0);
        check("abortMemAdr", 32'(memAdr), 32'd0);
        check("abortWriteData", 32'(writeData), 32'd0);
        check("abortBusy", 32'(busy), 32'd0);
        check("abortAck", 32'({ack1, ack0}), 32'd0);
        req1 = 1'b0; we1 = 1'b0;
        step();
        step();
        rst = 1'b1;
        step();
        step();
        check("abortMemKept", 32'(memModel[12'h020]), 32'h0000);
        req0 = 1'b1; addr0 = 12'h020;
        sbQ.push_back('{1'b0, 1'b1, 16'h0000});
        drain(10);

        // request withdrawn during ACCESS still completes
        step();
        req0 = 1'b1; addr0 = 12'h010;
        sbQ.push_back('{1'b0, 1'b1, 16'hBEEF});
        start = cyc;
        step();
        req0 = 1'b0;
        step();
        check("dropAck0", 32'(ack0), 32'd1);
        check("dropSbEmpty", 32'(sbQ.size()), 32'd0);
        step();
        step();
        check("dropIdleBusy", 32'(busy), 32'd0);
        check("dropIdleAck", 32'({ack1, ack0}), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
